// File: rtl/enc_event_arbiter.sv
// Round-robin arbiter serialising per-channel encoder events into a code FIFO.
// Latency: event captured at edge k, pushed at edge k+1, visible on o_out_valid after k+1.
// Backpressure: full FIFO stalls grants; pending bits hold, and repeat events on them raise o_ovf_flag.
module enc_event_arbiter #(
    parameter int N_ENC      = 8,
    parameter int CODE_W     = 6,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N_ENC-1:0]  i_ev_req,
    input  logic [N_ENC-1:0]  i_ev_dir,
    output logic              o_out_valid,
    output logic [CODE_W-1:0] o_out_code,
    input  logic              i_out_ready,
    output logic [CNT_W-1:0]  o_fifo_count,
    output logic              o_ovf_flag,
    input  logic              i_ovf_clr
);
    localparam int RR_W  = (N_ENC > 1) ? $clog2(N_ENC) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [N_ENC-1:0]  r_pend;
    logic [N_ENC-1:0]  r_dir;
    logic [RR_W-1:0]   r_rr_ptr;
    logic [CODE_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_ovf;

    logic              w_valid;
    logic              w_full;
    logic              w_any_grant;
    logic              w_push;
    logic              w_pop;
    logic [RR_W-1:0]   w_grant;
    logic [N_ENC-1:0]  w_grant_mask;
    logic [N_ENC-1:0]  w_ovf_hit;
    logic [CODE_W-1:0] w_push_code;

    function automatic logic [RR_W-1:0] wrap_idx(input int s);
        if (s >= N_ENC) return RR_W'(s - N_ENC);
        return RR_W'(s);
    endfunction

    // Scan from the round-robin pointer; first pending channel wins.
    always_comb begin
        w_any_grant = 1'b0;
        w_grant     = '0;
        for (int k = 0; k < N_ENC; k++) begin
            if (!w_any_grant && r_pend[wrap_idx(int'(r_rr_ptr) + k)]) begin
                w_any_grant = 1'b1;
                w_grant     = wrap_idx(int'(r_rr_ptr) + k);
            end
        end
    end

    assign w_valid      = (r_count != '0);
    assign w_full       = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_push       = w_any_grant && !w_full;
    assign w_pop        = w_valid && i_out_ready;
    assign w_grant_mask = w_push ? (N_ENC'(1) << w_grant) : '0;
    // A re-capture on the channel being granted this cycle is not a loss.
    assign w_ovf_hit    = i_ev_req & r_pend & ~w_grant_mask;
    assign w_push_code  = CODE_W'({w_grant, r_dir[w_grant]});

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pend   <= '0;
            r_dir    <= '0;
            r_rr_ptr <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_pend  <= (r_pend & ~w_grant_mask) | i_ev_req;
            r_dir   <= (r_dir & ~i_ev_req) | (i_ev_dir & i_ev_req);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            if (w_push) begin
                r_rr_ptr <= wrap_idx(int'(w_grant) + 1);
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (|w_ovf_hit) begin
                r_ovf <= 1'b1;
            end else if (i_ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_code;
        end
    end

    assign o_out_valid  = w_valid;
    assign o_out_code   = w_valid ? r_mem[r_rd_ptr] : '0;
    assign o_fifo_count = r_count;
    assign o_ovf_flag   = r_ovf;
endmodule

// File: tb/tb_enc_event_arbiter.sv
// Bench for enc_event_arbiter: queue-based reference model checked every cycle plus directed literals.
module tb_enc_event_arbiter;
    localparam int N     = 8;
    localparam int CW    = 6;
    localparam int DEPTH = 8;
    localparam int CNTW  = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    ev_req = '0;
    logic [N-1:0]    ev_dir = '0;
    logic            out_ready = 1'b0;
    logic            ovf_clr = 1'b0;
    logic            out_valid;
    logic [CW-1:0]   out_code;
    logic [CNTW-1:0] fifo_count;
    logic            ovf_flag;

    int checks = 0;
    int errors = 0;

    enc_event_arbiter #(.N_ENC(N), .CODE_W(CW), .FIFO_DEPTH(DEPTH), .CNT_W(CNTW)) dut (
        .i_clk(clk), .i_rst(rst), .i_ev_req(ev_req), .i_ev_dir(ev_dir),
        .o_out_valid(out_valid), .o_out_code(out_code), .i_out_ready(out_ready),
        .o_fifo_count(fifo_count), .o_ovf_flag(ovf_flag), .i_ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: pending set, direction memory, round-robin pointer, code queue.
    int m_q[$];
    bit m_pend[N];
    bit m_dir[N];
    int m_rr;
    bit m_ovf;
    int m_g;
    bit m_full;
    bit m_lost;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            for (int i = 0; i < N; i++) begin
                m_pend[i] = 1'b0;
                m_dir[i]  = 1'b0;
            end
            m_rr  = 0;
            m_ovf = 1'b0;
        end else begin
            m_full = (m_q.size() == DEPTH);
            m_g = -1;
            if (!m_full)
                for (int k = 0; k < N; k++)
                    if (m_g < 0 && m_pend[(m_rr + k) % N]) m_g = (m_rr + k) % N;
            if (m_q.size() != 0 && out_ready) void'(m_q.pop_front());
            if (m_g >= 0) begin
                m_q.push_back(2 * m_g + int'(m_dir[m_g]));
                m_pend[m_g] = 1'b0;
                m_rr = (m_g + 1) % N;
            end
            m_lost = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (ev_req[i]) begin
                    if (m_pend[i]) m_lost = 1'b1;
                    m_pend[i] = 1'b1;
                    m_dir[i]  = ev_dir[i];
                end
            end
            if (m_lost) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("model_valid", int'(out_valid), int'(m_q.size() != 0));
            chk("model_count", int'(fifo_count), m_q.size());
            chk("model_ovf", int'(ovf_flag), int'(m_ovf));
            if (m_q.size() != 0) chk("model_code", int'(out_code), m_q[0]);
        end
    end

    task automatic cyc(input logic [N-1:0] req, input logic [N-1:0] dir,
                       input logic rdy, input logic clr);
        @(negedge clk);
        ev_req = req; ev_dir = dir; out_ready = rdy; ovf_clr = clr;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; ev_req = '0; ev_dir = '0; out_ready = 1'b0; ovf_clr = 1'b0;
        @(negedge clk);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_count", int'(fifo_count), 0);
        chk("rst_code", int'(out_code), 0);
        chk("rst_ovf", int'(ovf_flag), 0);
        rst = 1'b0;
    endtask

    task automatic wait_count(input string name, input int target, input int limit);
        int n;
        n = 0;
        while (int'(fifo_count) != target && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, int'(fifo_count), target);
    endtask

    int got[$];
    // Records each head that will pop on the next edge (out_ready must be 1).
    task automatic collect(input int n, input int limit);
        int c;
        got.delete();
        c = 0;
        while (got.size() < n && c < limit) begin
            if (out_valid && out_ready) got.push_back(int'(out_code));
            @(posedge clk); #1;
            c++;
        end
        chk("collect_len", got.size(), n);
    endtask

    initial begin
        int exp_rr[6];
        int exp_full[9];
        exp_rr = '{2, 12, 2, 12, 2, 12};
        exp_full = '{0, 2, 4, 6, 8, 10, 12, 14, 0};

        do_reset();

        // Single event: channel 3, negative -> code 7 two edges later.
        cyc(8'h08, 8'h08, 1'b1, 1'b0);
        cyc(8'h00, 8'h00, 1'b1, 1'b0);
        chk("lat_early_valid", int'(out_valid), 0);
        @(posedge clk); #1;
        chk("lat_valid", int'(out_valid), 1);
        chk("lat_code", int'(out_code), 7);
        @(posedge clk); #1;
        chk("lat_drain", int'(fifo_count), 0);

        // Simultaneous channels 0 and 2, twice (second time rr sits at 3).
        do_reset();
        for (int r = 0; r < 2; r++) begin
            cyc(8'h05, 8'h00, 1'b1, 1'b0);
            cyc(8'h00, 8'h00, 1'b1, 1'b0);
            @(posedge clk); #1;
            chk("sim_first", int'(out_code), 0);
            @(posedge clk); #1;
            chk("sim_second", int'(out_code), 4);
            @(posedge clk); #1;
        end

        // Round robin with channels 1 and 6 held active.
        do_reset();
        cyc(8'h42, 8'h00, 1'b1, 1'b0);
        collect(6, 30);
        for (int i = 0; i < 6; i++)
            if (i < got.size()) chk("rr_code", got[i], exp_rr[i]);
        chk("rr_ovf", int'(ovf_flag), 1);
        cyc(8'h00, 8'h00, 1'b1, 1'b0);
        wait_count("rr_drain", 0, 20);

        // Fill the FIFO one channel per cycle, plus one extra event on channel 0.
        do_reset();
        for (int i = 0; i < N; i++) cyc(N'(1) << i, 8'h00, 1'b0, 1'b0);
        cyc(8'h01, 8'h00, 1'b0, 1'b0);
        cyc(8'h00, 8'h00, 1'b0, 1'b0);
        cyc(8'h00, 8'h00, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("full_count", int'(fifo_count), 8);
        @(negedge clk);
        out_ready = 1'b1;
        collect(9, 40);
        for (int i = 0; i < 9; i++)
            if (i < got.size()) chk("full_code", got[i], exp_full[i]);
        chk("full_no_ovf", int'(ovf_flag), 0);

        // Overflow, clear, and clear colliding with a new overflow.
        do_reset();
        cyc(8'hFF, 8'h00, 1'b0, 1'b0);
        cyc(8'h00, 8'h00, 1'b0, 1'b0);
        wait_count("ovf_fill", 8, 20);
        cyc(8'h20, 8'h20, 1'b0, 1'b0);
        chk("ovf_first_pulse", int'(ovf_flag), 0);
        cyc(8'h20, 8'h00, 1'b0, 1'b0);
        cyc(8'h00, 8'h00, 1'b0, 1'b0);
        chk("ovf_set", int'(ovf_flag), 1);
        cyc(8'h00, 8'h00, 1'b0, 1'b1);
        cyc(8'h00, 8'h00, 1'b0, 1'b0);
        chk("ovf_cleared", int'(ovf_flag), 0);
        cyc(8'h20, 8'h00, 1'b0, 1'b1);
        cyc(8'h00, 8'h00, 1'b0, 1'b0);
        chk("ovf_set_wins", int'(ovf_flag), 1);

        // Asynchronous reset with five queued codes.
        do_reset();
        cyc(8'h1F, 8'h00, 1'b0, 1'b0);
        cyc(8'h00, 8'h00, 1'b0, 1'b0);
        wait_count("arst_fill", 5, 20);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_count", int'(fifo_count), 0);
        @(negedge clk);
        rst = 1'b0;
        cyc(8'h04, 8'h04, 1'b1, 1'b0);
        cyc(8'h00, 8'h00, 1'b1, 1'b0);
        chk("arst_lat_early", int'(out_valid), 0);
        @(posedge clk); #1;
        chk("arst_lat_valid", int'(out_valid), 1);
        chk("arst_lat_code", int'(out_code), 5);
        @(posedge clk); #1;
        chk("arst_drain", int'(fifo_count), 0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t limit 200000", $time);
        $fatal(1);
    end
endmodule
